// File: rtl/intpol2_d4_seq_if.sv
// Datapath handshake bundle between the interpolator sequencer and its
// surroundings: the paired I/Q input FIFOs, the interpolator core and the
// downstream sinks.
//
// Signals:
//   empty_I, empty_Q : input FIFO empty flags        (FIFOs -> sequencer)
//   afull_out        : downstream almost-full        (sinks -> sequencer)
//   read_en          : shared FIFO read enable       (sequencer -> FIFOs)
//   sample_valid     : fetched sample valid          (sequencer -> core)
//   phase            : interpolation phase index     (sequencer -> core)
//   out_valid        : core output valid / write en  (sequencer -> sinks)
//
// Modports:
//   master : the sequencer side
//   slave  : the FIFO/core/sink side
interface intpol2_d4_seq_if #(
  parameter int OSR_LOG2 = 2
);
  logic                empty_I;
  logic                empty_Q;
  logic                afull_out;
  logic                read_en;
  logic                sample_valid;
  logic [OSR_LOG2-1:0] phase;
  logic                out_valid;

  modport master (
    input  empty_I, empty_Q, afull_out,
    output read_en, sample_valid, phase, out_valid
  );

  modport slave (
    output empty_I, empty_Q, afull_out,
    input  read_en, sample_valid, phase, out_valid
  );
endinterface

// File: rtl/intpol2_d4_seq.sv
// Sequencer for the 2nd-order, interpolate-by-4 I/Q datapath.
// Fetches one paired I/Q sample per input step, qualifies it into the core,
// then walks the core through its output phases, stalling on downstream
// almost-full. Counts samples per frame and reports completion and stall /
// skew status to the AIP status register.
//
// Ports:
//   clk         : system clock, rising edge
//   rst_a       : asynchronous active-low reset
//   start       : single-cycle frame start pulse
//   frame_len   : input samples per frame, latched on an accepted start
//   dp          : datapath handshake bundle (master side)
//   busy        : frame in progress
//   done        : one-cycle pulse at frame completion
//   stop_empty  : stalled this cycle waiting on an empty input FIFO
//   stop_afull  : stalled this cycle on downstream almost-full
//   sync_err    : sticky I/Q empty-flag skew error
//   sample_cnt  : samples completed in the current frame
module intpol2_d4_seq #(
  parameter int CNT_WIDTH = 16,
  parameter int OSR_LOG2  = 2,
  parameter int SKEW_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] frame_len,
  intpol2_d4_seq_if.master     dp,
  output logic                 busy,
  output logic                 done,
  output logic                 stop_empty,
  output logic                 stop_afull,
  output logic                 sync_err,
  output logic [CNT_WIDTH-1:0] sample_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    FETCH,
    EMIT,
    DONE
  } state_t;

  localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;
  localparam int                  SKEW_W     = (SKEW_MAX < 2) ? 1 : $clog2(SKEW_MAX + 1);
  localparam logic [SKEW_W-1:0]   SKEW_LIM   = SKEW_W'(SKEW_MAX);

  state_t               state_q, state_d;
  logic [OSR_LOG2-1:0]  phase_q, phase_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [SKEW_W-1:0]    skew_q;
  logic                 sync_q;
  logic                 start_ok;
  logic                 read_en;
  logic                 sample_valid;
  logic                 out_valid;
  logic                 skewed;

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);
  assign skewed  = dp.empty_I ^ dp.empty_Q;

  // State, phase, sample counter and latched frame length registers.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state and output decode. A stalled EMIT cycle leaves phase_q
  // untouched, so every phase is emitted exactly once per sample. The phase
  // counter wraps naturally to 0 after the last phase, which is where the
  // next sample starts.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    start_ok     = 1'b0;
    read_en      = 1'b0;
    sample_valid = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    stop_empty   = 1'b0;
    stop_afull   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          cnt_d    = '0;
          phase_d  = '0;
          if (frame_len != '0) begin
            len_d   = frame_len;
            state_d = WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (dp.empty_I || dp.empty_Q) begin
          stop_empty = 1'b1;
        end else begin
          read_en = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy         = 1'b1;
        sample_valid = 1'b1;
        phase_d      = '0;
        state_d      = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (dp.afull_out) begin
          stop_afull = 1'b1;
        end else begin
          out_valid = 1'b1;
          phase_d   = phase_q + OSR_LOG2'(1);
          if (phase_q == PHASE_LAST) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? DONE : WAIT;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Skew monitor: counts consecutive busy cycles in which the I and Q empty
  // flags disagree. The error is sticky so a transient misalignment is still
  // visible to software after the frame ends; it never aborts the frame.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      skew_q <= '0;
      sync_q <= 1'b0;
    end else if (start_ok) begin
      skew_q <= '0;
      sync_q <= 1'b0;
    end else if (busy && skewed) begin
      if (skew_q != SKEW_LIM) begin
        skew_q <= skew_q + SKEW_W'(1);
      end
      if (skew_q >= SKEW_LIM - SKEW_W'(1)) begin
        sync_q <= 1'b1;
      end
    end else begin
      skew_q <= '0;
    end
  end

  assign dp.read_en      = read_en;
  assign dp.sample_valid = sample_valid;
  assign dp.out_valid    = out_valid;
  assign dp.phase        = phase_q;
  assign sync_err        = sync_q;
  assign sample_cnt      = cnt_q;

endmodule
